// File: rtl/poly_pointwise_engine_if.sv
// Bundle of command, BRAM read, AU and write-back signals for poly_pointwise_engine.
// Latency: none; this is wiring only.
// Backpressure: hold is the only throttle. The AU side is fixed-latency and is never stalled.
// Modports: master = the engine, slave = memories / AU / command source.
interface poly_pointwise_engine_if #(
    parameter int LANES   = 4,
    parameter int COEFF_W = 24,
    parameter int DEPTH   = 64,
    parameter int MAX_VEC = 8,
    parameter int DW      = LANES * COEFF_W,
    parameter int AW      = $clog2(MAX_VEC * DEPTH),
    parameter int VW      = $clog2(MAX_VEC + 1)
);
    logic          start;
    logic [2:0]    mode;
    logic [VW-1:0] vec_len;
    logic          hold;
    logic          busy;
    logic          done;
    logic          err;
    logic          rd_en_a;
    logic          rd_en_b;
    logic          rd_en_c;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [AW-1:0] rd_addr_c;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic [DW-1:0] rd_data_c;
    logic          au_valid_o;
    logic [2:0]    au_mode;
    logic [DW-1:0] au_a;
    logic [DW-1:0] au_b;
    logic [DW-1:0] au_acc;
    logic          au_valid_i;
    logic [DW-1:0] au_result;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (
        input  start, mode, vec_len, hold, rd_data_a, rd_data_b, rd_data_c, au_valid_i, au_result,
        output busy, done, err, rd_en_a, rd_en_b, rd_en_c, rd_addr_a, rd_addr_b, rd_addr_c,
               au_valid_o, au_mode, au_a, au_b, au_acc, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, mode, vec_len, hold, rd_data_a, rd_data_b, rd_data_c, au_valid_i, au_result,
        input  busy, done, err, rd_en_a, rd_en_b, rd_en_c, rd_addr_a, rd_addr_b, rd_addr_c,
               au_valid_o, au_mode, au_a, au_b, au_acc, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/poly_pointwise_engine.sv
// Coefficient-wise polynomial engine: streams {poly,word} reads to a fixed-latency AU and writes results back.
// Latency: done arrives vec_len*DEPTH + RD_LAT + ARITH_LAT + 1 cycles after start, plus one cycle per held issue cycle.
// Backpressure: hold stops new issues only. In-flight words keep moving, and AU results are never stalled.
// Ports: clk, rst (synchronous, active-low), bus (poly_pointwise_engine_if.master).
module poly_pointwise_engine #(
    parameter int LANES     = 4,
    parameter int COEFF_W   = 24,
    parameter int DEPTH     = 64,
    parameter int MAX_VEC   = 8,
    parameter int RD_LAT    = 1,
    parameter int ARITH_LAT = 8
) (
    input  logic clk,
    input  logic rst,
    poly_pointwise_engine_if.master bus
);
    localparam int DW = LANES * COEFF_W;
    localparam int AW = $clog2(MAX_VEC * DEPTH);
    localparam int VW = $clog2(MAX_VEC + 1);
    localparam int WW = $clog2(DEPTH);
    localparam int PW = AW - WW;
    localparam int FW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    mode_q;
    logic [VW-1:0] vec_len_q;
    logic [PW-1:0] poly_ctr;
    logic [WW-1:0] word_ctr;
    logic          rej_q;
    logic [FW-1:0] inflight;
    logic [FW-1:0] inflight_nxt;
    logic          issue;
    logic          retire;
    logic          last;
    logic          cmd_ok;
    logic          mac;

    // Read-latency pipe: valid, issue address and first-pass flag.
    logic [RD_LAT-1:0] rp_vld;
    logic [RD_LAT-1:0] rp_first;
    logic [AW-1:0]     rp_addr [RD_LAT];
    // AU-latency pipe: only the write address needs to travel here.
    logic [AW-1:0]     ap_addr [ARITH_LAT];

    assign cmd_ok = (bus.mode >= 3'd2) && (bus.mode <= 3'd5) &&
                    (bus.vec_len != '0) && (bus.vec_len <= VW'(MAX_VEC));
    assign mac    = (mode_q == 3'd5);
    assign last   = (VW'(poly_ctr) == vec_len_q - VW'(1)) && (word_ctr == WW'(DEPTH - 1));
    // Results that arrive while idle belong to an aborted command. They must not
    // unbalance the counter.
    assign retire = bus.au_valid_i && (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && cmd_ok) state_nxt = ISSUE;
            ISSUE:   if (issue && last) state_nxt = DRAIN;
            // Looking at the next count lets FINISH follow the last retire immediately.
            DRAIN:   if (inflight_nxt == '0) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue    = (state == ISSUE) && !bus.hold;
        bus.busy = (state != IDLE);
        bus.done = (state == FINISH) || rej_q;
        bus.err  = rej_q;
    end

    always_comb begin
        inflight_nxt = inflight;
        if (issue && !retire)      inflight_nxt = inflight + FW'(1);
        else if (!issue && retire) inflight_nxt = inflight - FW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q    <= '0;
            vec_len_q <= '0;
            poly_ctr  <= '0;
            word_ctr  <= '0;
            rej_q     <= 1'b0;
            inflight  <= '0;
            rp_vld    <= '0;
            rp_first  <= '0;
            for (int i = 0; i < RD_LAT; i++)    rp_addr[i] <= '0;
            for (int i = 0; i < ARITH_LAT; i++) ap_addr[i] <= '0;
        end else begin
            rej_q    <= (state == IDLE) && bus.start && !cmd_ok;
            inflight <= inflight_nxt;
            if (state == IDLE && bus.start) begin
                mode_q    <= bus.mode;
                vec_len_q <= bus.vec_len;
                poly_ctr  <= '0;
                word_ctr  <= '0;
            end else if (issue) begin
                if (last) begin
                    poly_ctr <= '0;
                    word_ctr <= '0;
                end else begin
                    word_ctr <= word_ctr + WW'(1);
                    if (word_ctr == WW'(DEPTH - 1)) poly_ctr <= poly_ctr + PW'(1);
                end
            end
            rp_vld[0]   <= issue;
            rp_first[0] <= (poly_ctr == '0);
            rp_addr[0]  <= {poly_ctr, word_ctr};
            for (int i = 1; i < RD_LAT; i++) begin
                rp_vld[i]   <= rp_vld[i-1];
                rp_first[i] <= rp_first[i-1];
                rp_addr[i]  <= rp_addr[i-1];
            end
            ap_addr[0] <= rp_addr[RD_LAT-1];
            for (int i = 1; i < ARITH_LAT; i++) ap_addr[i] <= ap_addr[i-1];
        end
    end

    assign bus.rd_en_a   = issue;
    assign bus.rd_en_b   = issue;
    assign bus.rd_addr_a = {poly_ctr, word_ctr};
    assign bus.rd_addr_b = {poly_ctr, word_ctr};
    // The accumulator lives in poly 0 of the result memory. It is only read once pass 0 has seeded it.
    assign bus.rd_en_c   = issue && mac && (poly_ctr != '0);
    assign bus.rd_addr_c = {{PW{1'b0}}, word_ctr};

    assign bus.au_valid_o = rp_vld[RD_LAT-1];
    assign bus.au_mode    = mode_q;
    assign bus.au_a       = rp_vld[RD_LAT-1] ? bus.rd_data_a : DW'(0);
    assign bus.au_b       = rp_vld[RD_LAT-1] ? bus.rd_data_b : DW'(0);
    assign bus.au_acc     = (rp_vld[RD_LAT-1] && mac && !rp_first[RD_LAT-1]) ? bus.rd_data_c : DW'(0);

    assign bus.wr_en   = bus.au_valid_i && (state != IDLE);
    assign bus.wr_addr = mac ? {{PW{1'b0}}, ap_addr[ARITH_LAT-1][WW-1:0]} : ap_addr[ARITH_LAT-1];
    assign bus.wr_data = bus.au_result;
endmodule

// File: tb/tb_poly_pointwise_engine.sv
// Bench for poly_pointwise_engine: BRAM and fixed-latency AU models, plus a write-back scoreboard.
// Latency: the command task waits a fixed number of cycles derived from the command.
// Backpressure: hold is driven for one scenario. Results are never stalled.
module tb_poly_pointwise_engine;
    localparam int LANES     = 4;
    localparam int COEFF_W   = 24;
    localparam int DEPTH     = 64;
    localparam int MAX_VEC   = 8;
    localparam int RD_LAT    = 1;
    localparam int ARITH_LAT = 8;
    localparam int DW = LANES * COEFF_W;
    localparam int AW = $clog2(MAX_VEC * DEPTH);
    localparam int VW = $clog2(MAX_VEC + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    poly_pointwise_engine_if #(.LANES(LANES), .COEFF_W(COEFF_W), .DEPTH(DEPTH), .MAX_VEC(MAX_VEC)) bus();

    poly_pointwise_engine #(
        .LANES(LANES), .COEFF_W(COEFF_W), .DEPTH(DEPTH), .MAX_VEC(MAX_VEC),
        .RD_LAT(RD_LAT), .ARITH_LAT(ARITH_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] mem_a [MAX_VEC*DEPTH];
    logic [DW-1:0] mem_b [MAX_VEC*DEPTH];
    logic [DW-1:0] mem_c [MAX_VEC*DEPTH];
    bit            au_v  [ARITH_LAT];
    logic [DW-1:0] au_d  [ARITH_LAT];
    logic [AW-1:0] sb_addr [$];
    logic [DW-1:0] sb_dat  [$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_cnt, rdc_cnt, rd_seq, rd_first, rd_last, vo_cnt;
    logic [2:0] cur_mode;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] au_fn(input logic [2:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] c);
        logic [DW-1:0]        r;
        logic [2*COEFF_W-1:0] p;
        logic [COEFF_W-1:0]   x, y, z;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            x = a[l*COEFF_W +: COEFF_W];
            y = b[l*COEFF_W +: COEFF_W];
            z = c[l*COEFF_W +: COEFF_W];
            p = x * y;
            case (m)
                3'd2:    r[l*COEFF_W +: COEFF_W] = p[COEFF_W-1:0];
                3'd3:    r[l*COEFF_W +: COEFF_W] = x + y;
                3'd4:    r[l*COEFF_W +: COEFF_W] = x - y;
                3'd5:    r[l*COEFF_W +: COEFF_W] = p[COEFF_W-1:0] + z;
                default: r[l*COEFF_W +: COEFF_W] = '0;
            endcase
        end
        return r;
    endfunction

    // BRAMs (one-cycle read) and the AU pipeline.
    assign bus.au_valid_i = au_v[ARITH_LAT-1];
    assign bus.au_result  = au_d[ARITH_LAT-1];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.wr_en === 1'b1) mem_c[bus.wr_addr] <= bus.wr_data;
        bus.rd_data_a <= mem_a[bus.rd_addr_a];
        bus.rd_data_b <= mem_b[bus.rd_addr_b];
        bus.rd_data_c <= mem_c[bus.rd_addr_c];
        au_v[0] <= (bus.au_valid_o === 1'b1);
        au_d[0] <= au_fn(bus.au_mode, bus.au_a, bus.au_b, bus.au_acc);
        for (int i = 1; i < ARITH_LAT; i++) begin
            au_v[i] <= au_v[i-1];
            au_d[i] <= au_d[i-1];
        end
    end

    // Monitor: read sequence, accumulator use, hold obedience and write-back scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.hold) chk("hold_rd", bus.rd_en_a, 1'b0);
            if (bus.rd_en_c === 1'b1) begin
                chk("rdc_pass", rd_seq >= DEPTH, 1'b1);
                chk("rd_addr_c", bus.rd_addr_c, rd_seq % DEPTH);
                rdc_cnt++;
            end
            if (bus.rd_en_a === 1'b1) begin
                if (rd_cnt == 0) rd_first = cyc;
                rd_last = cyc;
                rd_cnt++;
                chk("rd_en_b", bus.rd_en_b, 1'b1);
                chk("rd_addr_a", bus.rd_addr_a, rd_seq);
                chk("rd_addr_b", bus.rd_addr_b, rd_seq);
                rd_seq++;
            end
            if (bus.au_valid_o === 1'b1) begin
                if (cur_mode == 3'd5 && vo_cnt < DEPTH) chk("acc_pass0", bus.au_acc, '0);
                vo_cnt++;
            end
            if (bus.wr_en === 1'b1) begin
                chk("wr_pass", bus.wr_data, bus.au_result);
                if (sb_addr.size() == 0) begin
                    chk("wr_extra", 1'b1, 1'b0);
                end else begin
                    chk("wr_addr", bus.wr_addr, sb_addr.pop_front());
                    chk("wr_data", bus.wr_data, sb_dat.pop_front());
                end
            end
        end
    end

    task automatic push_expected(input logic [2:0] m, input int vl);
        logic [DW-1:0] acc [DEPTH];
        for (int w = 0; w < DEPTH; w++) acc[w] = '0;
        for (int p = 0; p < vl; p++) begin
            for (int w = 0; w < DEPTH; w++) begin
                if (m == 3'd5) begin
                    acc[w] = au_fn(m, mem_a[p*DEPTH+w], mem_b[p*DEPTH+w], acc[w]);
                    sb_addr.push_back(AW'(w));
                    sb_dat.push_back(acc[w]);
                end else begin
                    sb_addr.push_back(AW'(p*DEPTH + w));
                    sb_dat.push_back(au_fn(m, mem_a[p*DEPTH+w], mem_b[p*DEPTH+w], '0));
                end
            end
        end
    endtask

    task automatic clr_counts(input logic [2:0] m);
        cur_mode = m;
        rd_cnt   = 0;
        rdc_cnt  = 0;
        rd_seq   = 0;
        vo_cnt   = 0;
    endtask

    // hs: first cycle of a 5-cycle hold (0 = none). bs: cycle of a stray start (0 = none).
    task automatic run_cmd(input logic [2:0] m, input logic [VW-1:0] vl, input int hs, input int bs);
        bit legal;
        int n, exp_k;
        legal = (m >= 3'd2) && (m <= 3'd5) && (vl != 0) && (vl <= MAX_VEC);
        n     = int'(vl) * DEPTH;
        exp_k = legal ? n + RD_LAT + ARITH_LAT + 1 + ((hs > 0) ? 5 : 0) : 1;
        clr_counts(m);
        if (legal) push_expected(m, int'(vl));
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = m; bus.vec_len = vl;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= exp_k + 3; k++) begin
            bus.hold  = (hs > 0) && (k >= hs) && (k < hs + 5);
            bus.start = (bs > 0) && (k == bs);
            if (bs > 0 && k == bs) bus.mode = 3'd7;
            @(negedge clk);
            chk("busy", bus.busy, legal && (k <= exp_k));
            chk("done", bus.done, k == exp_k);
            chk("err", bus.err, !legal && (k == 1));
            @(posedge clk); #1;
        end
        bus.hold  = 1'b0;
        bus.start = 1'b0;
        chk("rd_count", rd_cnt, legal ? n : 0);
        chk("rdc_count", rdc_cnt, (legal && m == 3'd5) ? (int'(vl) - 1) * DEPTH : 0);
        if (legal && hs == 0) chk("rd_span", rd_last - rd_first + 1, n);
        chk("sb_empty", sb_addr.size(), 0);
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0; bus.mode = '0; bus.vec_len = '0; bus.hold = 1'b0;
        for (int i = 0; i < MAX_VEC*DEPTH; i++) begin
            mem_a[i] = {$urandom, $urandom, $urandom};
            mem_b[i] = {$urandom, $urandom, $urandom};
            mem_c[i] = {$urandom, $urandom, $urandom};
        end
        clr_counts(3'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_rd_en_a", bus.rd_en_a, 1'b0);
        chk("rst_rd_en_c", bus.rd_en_c, 1'b0);
        chk("rst_au_valid_o", bus.au_valid_o, 1'b0);
        chk("rst_wr_en", bus.wr_en, 1'b0);
        chk("rst_wr_addr", bus.wr_addr, '0);
        chk("rst_rd_addr_a", bus.rd_addr_a, '0);
        chk("rst_au_mode", bus.au_mode, '0);
        chk("rst_au_a", bus.au_a, '0);
        chk("rst_au_acc", bus.au_acc, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_cmd(3'd3, VW'(1), 0, 0);   // ADD, one poly
        run_cmd(3'd4, VW'(3), 0, 0);   // SUB, wraps into poly 1 and 2
        run_cmd(3'd5, VW'(4), 0, 0);   // MAC inner product
        run_cmd(3'd3, VW'(2), 20, 0);  // ADD with a 5-cycle hold
        run_cmd(3'd7, VW'(1), 0, 0);   // illegal mode
        run_cmd(3'd3, VW'(0), 0, 0);   // empty batch
        run_cmd(3'd2, VW'(9), 0, 0);   // oversize batch
        run_cmd(3'd2, VW'(2), 0, 30);  // MULT with a stray start while busy

        // Reset in the middle of a MULT.
        clr_counts(3'd2);
        push_expected(3'd2, 2);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode = 3'd2; bus.vec_len = VW'(2);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        sb_addr.delete();
        sb_dat.delete();
        @(negedge clk);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_au_in", bus.au_valid_i, 1'b1);
        chk("abort_wr_en", bus.wr_en, 1'b0);
        chk("abort_rd_en", bus.rd_en_a, 1'b0);
        chk("abort_au_vo", bus.au_valid_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        run_cmd(3'd3, VW'(1), 0, 0);   // ADD after the abort

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
